// File: rtl/led_pwm_mmio.sv
// led_pwm_mmio: memory-mapped LED/RGB PWM and millisecond timer; define LED_PWM_MILLIS_EN to include the timer.
module led_pwm_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
    parameter int          CLK_HZ       = 12_000_000,
    parameter logic [15:0] PRESCALE_RST = 16'd47
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        read_hit,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

`ifdef LED_PWM_MILLIS_EN
    localparam logic [1:0] CTRL_BITS = 2'b11;
`else
    localparam logic [1:0] CTRL_BITS = 2'b01;
`endif

    logic [31:0] duty;
    logic [15:0] prescale;
    logic [1:0]  ctrl;
    logic [31:0] millis;
    logic [15:0] pcnt;
    logic [7:0]  phase;

    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] mask;
    logic [1:0]  sel;
    logic        wr_duty;
    logic        wr_prescale;
    logic        wr_millis;
    logic        wr_ctrl;

    logic        rhit;
    logic [31:0] rword;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] rval;

    // Store decode: byte-lane enables and lane-replicated data for aligned, in-window stores
    always_comb begin
        be  = 4'b0000;
        wd  = write_data;
        sel = write_address[3:2];
        if (write_mem && write_address[31:4] == BASE_ADDR[31:4]) begin
            case (funct3)
                3'b000: begin
                    be = 4'b0001 << write_address[1:0];
                    wd = {4{write_data[7:0]}};
                end
                3'b001: begin
                    be = write_address[0] ? 4'b0000 : (write_address[1] ? 4'b1100 : 4'b0011);
                    wd = {2{write_data[15:0]}};
                end
                3'b010:  be = (write_address[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
                default: be = 4'b0000;
            endcase
        end
        mask        = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wr_duty     = |be && sel == 2'd0;
        wr_prescale = |be && sel == 2'd1;
        wr_millis   = |be && sel == 2'd2;
        wr_ctrl     = |be && sel == 2'd3;
    end

    // Configuration registers, merged per byte lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty     <= '0;
            prescale <= PRESCALE_RST;
            ctrl     <= '0;
        end else begin
            if (wr_duty)
                duty <= (duty & ~mask) | (wd & mask);
            if (wr_prescale)
                prescale <= (prescale & ~mask[15:0]) | (wd[15:0] & mask[15:0]);
            if (wr_ctrl)
                ctrl <= ((ctrl & ~mask[1:0]) | (wd[1:0] & mask[1:0])) & CTRL_BITS;
        end
    end

    // Prescaler and phase counter; a prescale store restarts the count but keeps the phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= '0;
            phase <= '0;
        end else if (wr_prescale) begin
            pcnt <= '0;
        end else if (pcnt >= prescale) begin
            pcnt  <= '0;
            phase <= phase + 8'd1;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // Registered PWM compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led   <= 1'b0;
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else begin
            led   <= ctrl[0] && phase < duty[7:0];
            red   <= ctrl[0] && phase < duty[15:8];
            green <= ctrl[0] && phase < duty[23:16];
            blue  <= ctrl[0] && phase < duty[31:24];
        end
    end

`ifdef LED_PWM_MILLIS_EN
    localparam logic [31:0] TICK_MAX = 32'(CLK_HZ / 1000 - 1);
    logic [31:0] tick;

    // Millisecond counter; a store wins over a coincident increment and restarts the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            millis <= '0;
            tick   <= '0;
        end else if (wr_millis) begin
            millis <= (millis & ~mask) | (wd & mask);
            tick   <= '0;
        end else if (ctrl[1]) begin
            if (tick == TICK_MAX) begin
                tick   <= '0;
                millis <= millis + 32'd1;
            end else begin
                tick <= tick + 32'd1;
            end
        end
    end
`else
    assign millis = '0;
`endif

    // Load path: select register, then lane, then extend; bad accesses return 0
    always_comb begin
        rhit = read_address[31:4] == BASE_ADDR[31:4];
        case (read_address[3:2])
            2'd0:    rword = duty;
            2'd1:    rword = {16'h0, prescale};
            2'd2:    rword = millis;
            default: rword = {30'h0, ctrl};
        endcase
        rbyte = rword[{read_address[1:0], 3'b000} +: 8];
        rhalf = read_address[1] ? rword[31:16] : rword[15:0];
        case (funct3)
            3'b000:  rval = {{24{rbyte[7]}}, rbyte};
            3'b001:  rval = read_address[0] ? 32'h0 : {{16{rhalf[15]}}, rhalf};
            3'b010:  rval = (read_address[1:0] == 2'b00) ? rword : 32'h0;
            3'b100:  rval = {24'h0, rbyte};
            3'b101:  rval = read_address[0] ? 32'h0 : {16'h0, rhalf};
            default: rval = 32'h0;
        endcase
    end

    // Registered load response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data <= '0;
            read_hit  <= 1'b0;
        end else begin
            read_data <= rhit ? rval : 32'h0;
            read_hit  <= rhit;
        end
    end

    wire unused_ok = &{1'b0, wr_millis};

endmodule

// File: tb/tb_led_pwm_mmio.sv
// tb_led_pwm_mmio: table vectors, randomized loads/stores against a byte-level model, PWM/millis/reset sequences.
module tb_led_pwm_mmio;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef LED_PWM_MILLIS_EN
    localparam logic [7:0] CTRL_M = 8'h03;
`else
    localparam logic [7:0] CTRL_M = 8'h01;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_mem = 1'b0;
    logic [2:0]  funct3 = 3'b010;
    logic [31:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_address = '0;
    logic [31:0] read_data;
    logic        read_hit;
    logic        led, red, green, blue;

    int tests = 0;
    int fails = 0;

    logic [7:0] m [16];

    led_pwm_mmio #(.BASE_ADDR(BASE), .CLK_HZ(12000), .PRESCALE_RST(16'd47)) dut (
        .clk(clk), .rst_n(rst_n), .write_mem(write_mem), .funct3(funct3),
        .write_address(write_address), .write_data(write_data),
        .read_address(read_address), .read_data(read_data), .read_hit(read_hit),
        .led(led), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [7:0]  off;
        logic [31:0] data;
        logic [31:0] exp_d;
        bit          exp_h;
    } vec_t;

    vec_t vt [28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        write_mem = 1'b1;
        funct3 = f;
        write_address = a;
        write_data = d;
        tick(1);
        write_mem = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f, input logic [31:0] a, output logic [31:0] d, output logic h);
        funct3 = f;
        read_address = a;
        tick(1);
        d = read_data;
        h = read_hit;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic m_reset();
        foreach (m[i]) m[i] = 8'h00;
        m[4] = 8'd47;
    endtask

    function automatic int acc_size(input logic [2:0] f);
        return (f == 3'b000 || f == 3'b100) ? 1 : (f == 3'b001 || f == 3'b101) ? 2 : (f == 3'b010) ? 4 : 0;
    endfunction

    task automatic m_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int n;
        int off;
        n = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : (f == 3'b010) ? 4 : 0;
        off = int'(a[3:0]);
        if (a[31:4] != BASE[31:4] || n == 0 || off % n != 0) return;
        for (int i = 0; i < n; i++) m[off + i] = 8'((d >> (8 * i)) & 32'hFF);
        m[6] = 8'h00;
        m[7] = 8'h00;
        m[12] = m[12] & CTRL_M;
        m[13] = 8'h00;
        m[14] = 8'h00;
        m[15] = 8'h00;
`ifndef LED_PWM_MILLIS_EN
        for (int i = 8; i < 12; i++) m[i] = 8'h00;
`endif
    endtask

    task automatic m_load(input logic [2:0] f, input logic [31:0] a, output logic [31:0] d, output logic h);
        int n;
        int off;
        longint v;
        n = acc_size(f);
        off = int'(a[3:0]);
        h = (a[31:4] == BASE[31:4]);
        d = 32'h0;
        if (!h || n == 0 || off % n != 0) return;
        v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(m[off + i]);
        if (f[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        d = 32'(v);
    endtask

    task automatic count_pwm(input int n, output int cl, output int cr, output int cg, output int cb);
        cl = 0; cr = 0; cg = 0; cb = 0;
        repeat (n) begin
            tick(1);
            cl += int'(led);
            cr += int'(red);
            cg += int'(green);
            cb += int'(blue);
        end
    endtask

    initial begin
        logic [31:0] d, ed, base_addr;
        logic        h, eh;
        int          cl, cr, cg, cb;
        logic [2:0]  f;

        vt[0]  = '{1'b0, 3'b010, 8'h00, 32'h0, 32'h0000_0000, 1'b1};
        vt[1]  = '{1'b0, 3'b010, 8'h04, 32'h0, 32'h0000_002F, 1'b1};
        vt[2]  = '{1'b0, 3'b010, 8'h08, 32'h0, 32'h0000_0000, 1'b1};
        vt[3]  = '{1'b0, 3'b010, 8'h0C, 32'h0, 32'h0000_0000, 1'b1};
        vt[4]  = '{1'b0, 3'b010, 8'h10, 32'h0, 32'h0000_0000, 1'b0};
        vt[5]  = '{1'b1, 3'b010, 8'h00, 32'h80FF_0140, 32'h0, 1'b0};
        vt[6]  = '{1'b0, 3'b000, 8'h03, 32'h0, 32'hFFFF_FF80, 1'b1};
        vt[7]  = '{1'b0, 3'b100, 8'h03, 32'h0, 32'h0000_0080, 1'b1};
        vt[8]  = '{1'b0, 3'b101, 8'h02, 32'h0, 32'h0000_80FF, 1'b1};
        vt[9]  = '{1'b1, 3'b001, 8'h01, 32'h0000_1234, 32'h0, 1'b0};
        vt[10] = '{1'b0, 3'b010, 8'h00, 32'h0, 32'h80FF_0140, 1'b1};
        vt[11] = '{1'b0, 3'b001, 8'h02, 32'h0, 32'hFFFF_80FF, 1'b1};
        vt[12] = '{1'b0, 3'b001, 8'h01, 32'h0, 32'h0000_0000, 1'b1};
        vt[13] = '{1'b0, 3'b010, 8'h02, 32'h0, 32'h0000_0000, 1'b1};
        vt[14] = '{1'b0, 3'b011, 8'h00, 32'h0, 32'h0000_0000, 1'b1};
        vt[15] = '{1'b1, 3'b000, 8'h05, 32'h0000_00AB, 32'h0, 1'b0};
        vt[16] = '{1'b0, 3'b010, 8'h04, 32'h0, 32'h0000_AB2F, 1'b1};
        vt[17] = '{1'b1, 3'b000, 8'h06, 32'h0000_00CD, 32'h0, 1'b0};
        vt[18] = '{1'b0, 3'b010, 8'h04, 32'h0, 32'h0000_AB2F, 1'b1};
        vt[19] = '{1'b1, 3'b100, 8'h00, 32'h0000_0000, 32'h0, 1'b0};
        vt[20] = '{1'b0, 3'b010, 8'h00, 32'h0, 32'h80FF_0140, 1'b1};
        vt[21] = '{1'b0, 3'b000, 8'h00, 32'h0, 32'h0000_0040, 1'b1};
        vt[22] = '{1'b0, 3'b100, 8'h01, 32'h0, 32'h0000_0001, 1'b1};
        vt[23] = '{1'b0, 3'b001, 8'h00, 32'h0, 32'h0000_0140, 1'b1};
        vt[24] = '{1'b1, 3'b001, 8'h02, 32'h0000_7FEE, 32'h0, 1'b0};
        vt[25] = '{1'b0, 3'b010, 8'h00, 32'h0, 32'h7FEE_0140, 1'b1};
        vt[26] = '{1'b0, 3'b000, 8'h02, 32'h0, 32'hFFFF_FFEE, 1'b1};
        vt[27] = '{1'b0, 3'b101, 8'h10, 32'h0, 32'h0000_0000, 1'b0};

        tick(1);
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_read_hit", 32'(read_hit), 32'h0);
        chk("reset_pwm", {28'h0, led, red, green, blue}, 32'h0);
        rst_n = 1'b1;
        tick(1);

        for (int i = 0; i < 28; i++) begin
            if (vt[i].st) begin
                do_store(vt[i].f3, BASE + 32'(vt[i].off), vt[i].data);
            end else begin
                do_load(vt[i].f3, BASE + 32'(vt[i].off), d, h);
                chk($sformatf("vec%0d_data", i), d, vt[i].exp_d);
                chk($sformatf("vec%0d_hit", i), 32'(h), 32'(vt[i].exp_h));
            end
        end

        write_mem = 1'b1;
        write_address = BASE;
        write_data = 32'hA5A5_A5A5;
        do_load(3'b010, BASE, d, h);
        write_mem = 1'b0;
        chk("same_edge_old", d, 32'h7FEE_0140);
        do_load(3'b010, BASE, d, h);
        chk("same_edge_new", d, 32'hA5A5_A5A5);

        do_reset();
        m_reset();
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       base_addr = BASE + 32'h10 + 32'($urandom_range(0, 255));
                1:       base_addr = BASE - 32'($urandom_range(1, 64));
                default: base_addr = BASE + 32'($urandom_range(0, 15));
            endcase
            f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1 && !(base_addr[31:4] == BASE[31:4] && base_addr[3:2] == 2'd3)) begin
                d = $urandom;
                do_store(f, base_addr, d);
                m_store(f, base_addr, d);
            end
            base_addr = ($urandom_range(0, 4) == 0) ? $urandom : BASE + 32'($urandom_range(0, 15));
            f = 3'($urandom_range(0, 7));
            do_load(f, base_addr, d, h);
            m_load(f, base_addr, ed, eh);
            chk($sformatf("rnd%0d_f%0d_a%h_data", i, f, base_addr), d, ed);
            chk($sformatf("rnd%0d_hit", i), 32'(h), 32'(eh));
        end

        do_store(3'b010, BASE + 4, 32'h0);
        do_store(3'b010, BASE, 32'h80FF_4000);
        do_store(3'b010, BASE + 12, 32'h1);
        tick(2);
        count_pwm(256, cl, cr, cg, cb);
        chk("pwm0_led_duty0", 32'(cl), 32'd0);
        chk("pwm0_red_duty64", 32'(cr), 32'd64);
        chk("pwm0_green_duty255", 32'(cg), 32'd255);
        chk("pwm0_blue_duty128", 32'(cb), 32'd128);
        do_store(3'b000, BASE + 12, 32'h0);
        tick(2);
        count_pwm(256, cl, cr, cg, cb);
        chk("pwm_disabled", 32'(cl + cr + cg + cb), 32'd0);
        do_store(3'b010, BASE + 4, 32'h3);
        do_store(3'b000, BASE + 12, 32'h1);
        tick(2);
        count_pwm(1024, cl, cr, cg, cb);
        chk("pwm3_red", 32'(cr), 32'd256);
        chk("pwm3_green", 32'(cg), 32'd1020);
        chk("pwm3_blue", 32'(cb), 32'd512);

`ifdef LED_PWM_MILLIS_EN
        do_reset();
        do_store(3'b010, BASE + 12, 32'h2);
        tick(59);
        do_load(3'b010, BASE + 8, d, h);
        chk("millis_before_5", d, 32'd4);
        do_load(3'b010, BASE + 8, d, h);
        chk("millis_5", d, 32'd5);
        do_store(3'b010, BASE + 8, 32'hFFFF_FFFF);
        tick(11);
        do_load(3'b010, BASE + 8, d, h);
        chk("millis_max", d, 32'hFFFF_FFFF);
        do_load(3'b010, BASE + 8, d, h);
        chk("millis_rollover", d, 32'h0);
        tick(10);
        do_store(3'b010, BASE + 8, 32'd100);
        do_load(3'b010, BASE + 8, d, h);
        chk("millis_store_wins", d, 32'd100);
        tick(10);
        do_load(3'b010, BASE + 8, d, h);
        chk("millis_restart_hold", d, 32'd100);
        do_load(3'b010, BASE + 8, d, h);
        chk("millis_restart_inc", d, 32'd101);
        do_store(3'b010, BASE + 12, 32'h0);
        tick(40);
        do_load(3'b010, BASE + 8, d, h);
        chk("millis_stopped", d, 32'd101);
        do_store(3'b010, BASE + 12, 32'h3);
        do_load(3'b010, BASE + 12, d, h);
        chk("ctrl_readback", d, 32'h3);
`else
        do_store(3'b010, BASE + 8, 32'd5);
        do_load(3'b010, BASE + 8, d, h);
        chk("nomillis_data", d, 32'h0);
        chk("nomillis_hit", 32'(h), 32'h1);
        do_store(3'b010, BASE + 12, 32'h3);
        do_load(3'b010, BASE + 12, d, h);
        chk("ctrl_readback", d, 32'h1);
`endif

        do_store(3'b010, BASE + 4, 32'h0);
        do_store(3'b010, BASE, 32'h8080_8080);
        do_load(3'b010, BASE, d, h);
        chk("pre_reset_load", d, 32'h8080_8080);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pwm_zero", {28'h0, led, red, green, blue}, 32'h0);
        chk("async_read_data_zero", read_data, 32'h0);
        chk("async_read_hit_zero", 32'(read_hit), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_load(3'b010, BASE, d, h);
        chk("post_reset_duty", d, 32'h0);
        do_load(3'b010, BASE + 4, d, h);
        chk("post_reset_prescale", d, 32'd47);
        do_load(3'b010, BASE + 8, d, h);
        chk("post_reset_millis", d, 32'h0);
        do_load(3'b010, BASE + 12, d, h);
        chk("post_reset_ctrl", d, 32'h0);

        rst_n = 1'b0;
        do_store(3'b010, BASE, 32'h1234_5678);
        rst_n = 1'b1;
        tick(1);
        do_load(3'b010, BASE, d, h);
        chk("aborted_store", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_pwm_mmio.md
# led_pwm_mmio

Memory-mapped LED/RGB PWM and millisecond-timer peripheral that responds to the processor's load/store bus. It sits on the data side of the memory interface, decodes a 16-byte address window, and services byte/halfword/word loads and stores with the same funct3 encoding the core issues. It drives PWM-modulated LED/RGB outputs and a free-running millisecond counter that software can read.

## Interface
Parameters:
- BASE_ADDR, 32'hFFFF_FF00, word-aligned base of the 16-byte register window
- CLK_HZ, 12_000_000, clock frequency used to derive the 1 ms tick
- PRESCALE_RST, 16'd47, reset value of the PWM prescaler register

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- write_mem  in  1  store strobe; a store commits on the rising edge where it is high
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- write_address  in  32  store byte address
- write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- read_address  in  32  load byte address, sampled every cycle
- read_data  out  32  registered load data, sign/zero-extended per funct3
- read_hit  out  1  registered; 1 when the sampled read_address fell in the window
- led, red, green, blue  out  1 each  registered PWM outputs, 1 = lit (top level inverts for the board)

## Operation
- Register map (offset from BASE_ADDR):
  - 0x0: DUTY, byte 0 = led, 1 = red, 2 = green, 3 = blue; read/write
  - 0x4: PRESCALE[15:0]; upper bits read 0, writes ignored
  - 0x8: MILLIS[31:0]; read/write
  - 0xC: CTRL, bit0 = PWM enable, bit1 = millis run; other bits read 0
- Stores: sb writes one byte lane at addr[1:0]; sh writes lanes {addr[1],0}..+1 and requires addr[0]=0; sw requires addr[1:0]=0. Misaligned or out-of-window stores are ignored. Unknown funct3 values are ignored.
- Loads: the lane is selected by addr[1:0]. b/h sign-extend and bu/hu zero-extend. A misaligned, out-of-window or unknown-funct3 load returns read_data=0. read_hit is 0 for out-of-window loads only.
- PWM: a 16-bit prescaler counts 0..PRESCALE and then wraps. Each wrap advances an 8-bit phase (0..255, wraps to 0). Each output is CTRL[0] && (phase < duty). Duty 0 means always off; duty 255 means on for 255/256 of the period. PRESCALE=0 advances the phase every cycle. A write to PRESCALE resets the prescaler count to 0 and leaves the phase unchanged.
- Millis: a tick counter counts 0..CLK_HZ/1000-1 while CTRL[1]=1. MILLIS increments on wrap and rolls over from 32'hFFFF_FFFF to 0. Any store to MILLIS loads the merged value and clears the tick counter. If a store and an increment occur on the same edge, the store wins. When CTRL[1]=0 both the tick counter and MILLIS hold.

## Timing
- Reset (async assert, clocked release): DUTY=0, PRESCALE=PRESCALE_RST, MILLIS=0, CTRL=0, all counters 0. All outputs are 0: led/red/green/blue=0, read_data=0, read_hit=0.
- Load latency is 1 cycle. read_data and read_hit reflect the read_address and funct3 sampled on the previous edge.
- A load of a register on the same edge as a store to it returns the pre-store value. The store is visible to a load issued on the next cycle.
- A DUTY/CTRL store affects the PWM outputs on the edge after the store edge, which is 1 cycle of registered compare.
- MILLIS increments exactly every CLK_HZ/1000 cycles while running.
- Asserting rst_n low mid-access aborts the access. No partial write survives.

## Configuration
- LED_PWM_MILLIS_EN defined: the millisecond timer, MILLIS register and CTRL[1] are implemented as described.
- LED_PWM_MILLIS_EN undefined: the timer logic is removed. Offset 0x8 reads 0 with read_hit=1 and stores to it are ignored. CTRL[1] reads 0.

## Test plan
- Reset then read sweep: load lw at 0x0, 0x4, 0x8 and 0xC -> 0, 47, 0 and 0, with read_hit=1. lw at BASE_ADDR+0x10 -> read_data=0, read_hit=0.
- Byte lanes: sw DUTY=0x80FF0140, then lb at 0x3 -> 0xFFFFFF80, lbu at 0x3 -> 0x80, lhu at 0x2 -> 0x80FF. sh to offset 0x1 is ignored and DUTY is unchanged.
- PWM: PRESCALE=0, CTRL=1, red duty=64. Over 256 cycles red is high for exactly 64 cycles. Duty 0 -> never high. Duty 255 -> low for exactly 1 of 256 cycles.
- Millis: CLK_HZ=12000, CTRL=2. MILLIS reads 5 after 60 cycles. sw MILLIS=0xFFFFFFFF -> reads 0 after 12 more cycles. A store coinciding with a tick loads the stored value.
- Async reset mid-run: assert rst_n low during PWM and millis activity. All outputs go to 0 immediately and registers return to their reset values.
- Build without LED_PWM_MILLIS_EN: sw MILLIS=5 then lw MILLIS -> 0. CTRL write of 3 reads back 1.
